hash_nonce_scheduler: RTL and testbench
=======================================

# hash_nonce_scheduler

Sequencing controller for the 16-byte → 24-bit micro hash core. It takes a 12-byte payload and a start nonce and drives the core one nonce at a time. Each hash is checked against a difficulty target, and the controller stops on the first qualifying nonce or when the nonce space is exhausted. It sits between the host/register interface and a single hash core instance, and owns the core's input bus.

## Interface
Parameters:
- CORE_LAT, 1: cycles from `core_en` high to `core_hash` valid; legal range 1–15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a search; sampled only in IDLE.
- abort  in  1  cancel a search; sampled in any non-IDLE state.
- payload  in  96  bytes 0..11; byte i = payload[8i+7:8i].
- nonce_start  in  32  first nonce tried; latched on start.
- target  in  8  difficulty; latched on start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a search ends normally.
- found  out  1  valid from the done pulse until the next start.
- nonce_out  out  32  winning nonce, or the last nonce tried if not found.
- hash_out  out  24  {byte0,byte1,byte2} of the core hash for nonce_out.
- tries  out  32  number of nonces issued since the last start (see Configuration).
- core_block  out  128  core input; byte i = core_block[8i+7:8i].
- core_en  out  1  core evaluate strobe.
- core_hash  in  24  core result; [23:16]=byte0, [15:8]=byte1, [7:0]=byte2.

## Operation
- core_block bytes 0..11 come from a payload copy latched on start.
- core_block bytes 12..15 carry the nonce: byte12=nonce[31:24], byte13=nonce[23:16], byte14=nonce[15:8], byte15=nonce[7:0].
- core_block is held stable for a whole try.
- Qualify rule: core_hash byte0 < target AND byte1 < target, unsigned. Byte2 is ignored. target=0 never qualifies.
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE → ISSUE on start. On that edge, latch payload/target and load nonce=nonce_start. Clear found, nonce_out, hash_out and tries.
- ISSUE: core_en=1 for exactly 1 cycle, tries+1, then → WAIT.
- WAIT: stay CORE_LAT cycles (4-bit down counter), then → CHECK.
- CHECK: capture core_hash into hash_out and nonce into nonce_out.
  - If the hash qualifies: found=1, → DONE.
  - Else if nonce==32'hFFFF_FFFF: found=0, → DONE. No wrap to 0.
  - Else nonce+1, → ISSUE.
- DONE: done=1 for 1 cycle, then → IDLE. Results hold until the next start.
- abort in ISSUE/WAIT/CHECK/DONE: → IDLE next cycle.
  - No done pulse; found=0.
  - nonce_out/hash_out keep their last captured values.
  - abort has priority over a same-cycle qualify.
- start while busy: ignored. start and abort together in IDLE: start wins.
- reset overrides everything and returns the FSM to IDLE.

## Timing
- Reset values: busy=0, done=0, found=0, nonce_out=0, hash_out=0, tries=0, core_block=0, core_en=0.
- Start sampled at cycle 0 → ISSUE at cycle 1.
- Each try takes CORE_LAT+2 cycles.
- If the hit is on the n-th try (n=1 first): CHECK at cycle n·(CORE_LAT+2), done at cycle n·(CORE_LAT+2)+1.
- busy rises the cycle after start and falls the cycle after the done pulse.

## Configuration
- HASH_SCHED_STATS_EN defined: tries is a live 32-bit saturating counter (holds at 32'hFFFF_FFFF).
- HASH_SCHED_STATS_EN undefined: the counter is not built and tries is tied to 0.
- FSM timing is identical either way.

## Structure
- Shared package hash_sched_pkg holds:
  - the state enum;
  - NONCE_W=32, BLOCK_BYTES=16, PAYLOAD_BYTES=12, NONCE_BYTE0=12;
  - the all-ones nonce limit constant.
- One sub-module, hash_target_cmp: combinational qualify rule (core_hash, target → qualify). It is reused by the bench scoreboard.
- The hash core is instantiated by the parent, not inside this block.

## Test plan
- Scripted core model returns 24'hFFFFFF except 24'h101000 at nonce 5; CORE_LAT=1, nonce_start=0, target=8'h20 → done at cycle 19, found=1, nonce_out=5, hash_out=24'h101000, tries=6.
- Same model, nonce_start=32'hFFFF_FFFE, no hit → two tries, done at cycle 7, found=0, nonce_out=32'hFFFF_FFFF, tries=2.
- CORE_LAT=3, hit at nonce_start → core_en high only in cycle 1, CHECK at cycle 5, done at cycle 6.
- abort asserted at cycle 10 of the first scenario → IDLE at cycle 11, no done pulse, found=0, busy=0 at cycle 11.
- start pulsed at cycle 4 while busy → ignored, same results as the first scenario. reset at cycle 8 → all outputs at reset values at cycle 9.
- Real core, payload all 0, nonce_start=0, target=8'hFF → matches the reference model on the first qualifying nonce. Without HASH_SCHED_STATS_EN, tries=0 throughout.

Source files
------------

// File: rtl/hash_sched_pkg.sv
// hash_sched_pkg
// Shared definitions for the nonce scheduler and its qualify comparator:
//   - sched_state_t : scheduler FSM state encoding
//   - NONCE_W, BLOCK_BYTES, PAYLOAD_BYTES, NONCE_BYTE0 : block geometry
//   - NONCE_LIMIT   : last nonce of the search space (no wrap past it)
//   - nonce_to_bytes: places a nonce MSB-first into core block bytes 12..15
package hash_sched_pkg;

    localparam int NONCE_W       = 32;
    localparam int BLOCK_BYTES   = 16;
    localparam int PAYLOAD_BYTES = 12;
    localparam int NONCE_BYTE0   = 12;

    localparam logic [NONCE_W-1:0] NONCE_LIMIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // Byte 12 of the block is the most significant nonce byte, and byte i
    // lives at bits [8i+7:8i], so the nonce appears byte-reversed in the bus.
    function automatic logic [8*(BLOCK_BYTES-NONCE_BYTE0)-1:0] nonce_to_bytes(
        input logic [NONCE_W-1:0] nonce
    );
        return {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
    endfunction

endpackage

// File: rtl/hash_target_cmp.sv
// hash_target_cmp
// Combinational difficulty check for one core result.
// A hash qualifies when both of its first two bytes are strictly below the
// target; the third byte does not take part. A target of zero never qualifies.
// Ports:
//   core_hash [23:0] in  : {byte0, byte1, byte2} of the core result
//   target    [7:0]  in  : difficulty threshold
//   qualify          out : 1 when the hash meets the target
module hash_target_cmp (
    input  logic [23:0] core_hash,
    input  logic [7:0]  target,
    output logic        qualify
);

    assign qualify = (core_hash[23:16] < target) && (core_hash[15:8] < target);

endmodule

// File: rtl/hash_nonce_scheduler.sv
// hash_nonce_scheduler
// Drives a single 16-byte -> 24-bit hash core one nonce at a time, starting
// from nonce_start, and stops on the first hash that meets the target or
// after nonce 32'hFFFF_FFFF has been tried.
//
// Optional build macro: HASH_SCHED_STATS_EN
//   defined   : tries is a live saturating count of issued nonces
//   undefined : no counter is built and tries reads 0
//
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   start, abort        : begin a search (IDLE only) / cancel a search
//   payload[95:0]       : block bytes 0..11, latched on start
//   nonce_start[31:0]   : first nonce, latched on start
//   target[7:0]         : difficulty, latched on start
//   busy, done, found   : status; done is a one-cycle pulse
//   nonce_out, hash_out : winning (or last tried) nonce and its hash
//   tries[31:0]         : nonces issued since the last start
//   core_block, core_en : hash core input bus and evaluate strobe
//   core_hash[23:0]     : hash core result, valid CORE_LAT cycles after core_en
module hash_nonce_scheduler #(
    parameter int CORE_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [95:0]  payload,
    input  logic [31:0]  nonce_start,
    input  logic [7:0]   target,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  nonce_out,
    output logic [23:0]  hash_out,
    output logic [31:0]  tries,
    output logic [127:0] core_block,
    output logic         core_en,
    input  logic [23:0]  core_hash
);

    import hash_sched_pkg::*;

    localparam logic [3:0] WAIT_LOAD = 4'(CORE_LAT);

    sched_state_t               state_r;
    sched_state_t               state_nxt_s;
    logic [8*PAYLOAD_BYTES-1:0] payload_r;
    logic [7:0]                 target_r;
    logic [NONCE_W-1:0]         nonce_r;
    logic [NONCE_W-1:0]         nonce_out_r;
    logic [23:0]                hash_out_r;
    logic [3:0]                 wait_cnt_r;
    logic                       busy_r;
    logic                       done_r;
    logic                       found_r;
    logic                       core_en_r;
    logic                       qualify_s;
    logic                       start_acc_s;
    logic                       abort_acc_s;
    logic                       at_limit_s;

    hash_target_cmp u_cmp (
        .core_hash (core_hash),
        .target    (target_r),
        .qualify   (qualify_s)
    );

    assign start_acc_s = (state_r == IDLE) && start;
    assign abort_acc_s = (state_r != IDLE) && abort;
    assign at_limit_s  = (nonce_r == NONCE_LIMIT);

    // Next-state logic; abort wins over every other transition out of a busy state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            WAIT: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (wait_cnt_r <= 4'd1) begin
                    state_nxt_s = CHECK;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_nxt_s = IDLE;
                end else if (qualify_s || at_limit_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus status outputs registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            core_en_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            busy_r    <= (state_nxt_s != IDLE);
            done_r    <= (state_nxt_s == DONE);
            core_en_r <= (state_nxt_s == ISSUE);
        end
    end

    // WAIT dwell counter: loaded during ISSUE so WAIT lasts exactly CORE_LAT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_r <= 4'd0;
        end else if (state_r == ISSUE) begin
            wait_cnt_r <= WAIT_LOAD;
        end else if ((state_r == WAIT) && (wait_cnt_r != 4'd0)) begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Search datapath: operand latch on start, result capture in CHECK.
    // An abort skips the CHECK capture so results keep their previous values.
    always_ff @(posedge clk) begin
        if (reset) begin
            payload_r   <= '0;
            target_r    <= 8'd0;
            nonce_r     <= 32'd0;
            nonce_out_r <= 32'd0;
            hash_out_r  <= 24'd0;
            found_r     <= 1'b0;
        end else if (start_acc_s) begin
            payload_r   <= payload;
            target_r    <= target;
            nonce_r     <= nonce_start;
            nonce_out_r <= 32'd0;
            hash_out_r  <= 24'd0;
            found_r     <= 1'b0;
        end else if (abort_acc_s) begin
            found_r     <= 1'b0;
        end else if (state_r == CHECK) begin
            nonce_out_r <= nonce_r;
            hash_out_r  <= core_hash;
            found_r     <= qualify_s;
            // The last nonce of the space is never incremented past.
            if (!qualify_s && !at_limit_s) begin
                nonce_r <= nonce_r + 32'd1;
            end else begin
                nonce_r <= nonce_r;
            end
        end else begin
            nonce_r     <= nonce_r;
        end
    end

`ifdef HASH_SCHED_STATS_EN
    logic [31:0] tries_r;

    // Issued-nonce counter; counts every ISSUE cycle and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            tries_r <= 32'd0;
        end else if (start_acc_s) begin
            tries_r <= 32'd0;
        end else if ((state_r == ISSUE) && (tries_r != 32'hFFFF_FFFF)) begin
            tries_r <= tries_r + 32'd1;
        end else begin
            tries_r <= tries_r;
        end
    end

    assign tries = tries_r;
`else
    assign tries = 32'd0;
`endif

    assign busy       = busy_r;
    assign done       = done_r;
    assign found      = found_r;
    assign nonce_out  = nonce_out_r;
    assign hash_out   = hash_out_r;
    assign core_en    = core_en_r;
    assign core_block = {nonce_to_bytes(nonce_r), payload_r};

endmodule

// File: tb/tb_hash_nonce_scheduler.sv
// tb_hash_nonce_scheduler
// Self-checking bench: two scheduler instances (CORE_LAT=1 and CORE_LAT=3),
// each fed by a bench-side core model that is either scripted (one hit nonce)
// or a mixing hash with an independent reference search.
module tb_hash_nonce_scheduler;

`ifdef HASH_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always_ff @(posedge clk) cyc <= cyc + 1;

    logic         reset, abort, start1, start2;
    logic [95:0]  payload;
    logic [31:0]  nonce_start;
    logic [7:0]   target;

    logic         busy1, done1, found1, core_en1;
    logic [31:0]  nonce_out1, tries1;
    logic [23:0]  hash_out1, core_hash1;
    logic [127:0] core_block1;

    logic         busy2, done2, found2, core_en2;
    logic [31:0]  nonce_out2, tries2;
    logic [23:0]  hash_out2, core_hash2;
    logic [127:0] core_block2;

    logic         real_mode;
    logic [31:0]  hit_nonce;

    hash_nonce_scheduler #(.CORE_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort),
        .payload(payload), .nonce_start(nonce_start), .target(target),
        .busy(busy1), .done(done1), .found(found1), .nonce_out(nonce_out1),
        .hash_out(hash_out1), .tries(tries1), .core_block(core_block1),
        .core_en(core_en1), .core_hash(core_hash1)
    );

    hash_nonce_scheduler #(.CORE_LAT(3)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .abort(abort),
        .payload(payload), .nonce_start(nonce_start), .target(target),
        .busy(busy2), .done(done2), .found(found2), .nonce_out(nonce_out2),
        .hash_out(hash_out2), .tries(tries2), .core_block(core_block2),
        .core_en(core_en2), .core_hash(core_hash2)
    );

    logic [23:0] cmp_hash;
    logic [7:0]  cmp_tgt;
    logic        cmp_q;
    hash_target_cmp u_cmp (.core_hash(cmp_hash), .target(cmp_tgt), .qualify(cmp_q));

    // ---------------- reference functions ----------------
    function automatic logic [127:0] mk_block(input logic [95:0] pay, input logic [31:0] n);
        logic [127:0] b;
        for (int i = 0; i < 12; i++) b[8*i +: 8] = pay[8*i +: 8];
        b[103:96]  = n[31:24];
        b[111:104] = n[23:16];
        b[119:112] = n[15:8];
        b[127:120] = n[7:0];
        return b;
    endfunction

    function automatic logic [31:0] blk_nonce(input logic [127:0] b);
        return {b[103:96], b[111:104], b[119:112], b[127:120]};
    endfunction

    function automatic logic [23:0] mix_hash(input logic [127:0] b);
        logic [23:0] acc;
        acc = 24'h6A09E6;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ {b[8*i +: 8], ~b[8*i +: 8], b[8*i +: 8] + 8'(i)};
            acc = {acc[16:0], acc[23:17]} + 24'h9E3779;
            acc = acc ^ (acc >> 11);
        end
        return acc;
    endfunction

    function automatic logic ref_qualify(input logic [23:0] h, input logic [7:0] t);
        return (h[23:16] < t) && (h[15:8] < t);
    endfunction

    function automatic logic [23:0] core_fn(input logic [127:0] b);
        if (real_mode) return mix_hash(b);
        return (blk_nonce(b) == hit_nonce) ? 24'h101000 : 24'hFFFFFF;
    endfunction

    function automatic logic [31:0] tries_exp(input int k);
        return STATS ? 32'(k) : 32'd0;
    endfunction

    // ---------------- core models ----------------
    logic [23:0] pipe1;
    logic [23:0] pipe2 [3];

    always_ff @(posedge clk) pipe1 <= core_fn(core_block1);
    always_ff @(posedge clk) begin
        pipe2[0] <= core_fn(core_block2);
        pipe2[1] <= pipe2[0];
        pipe2[2] <= pipe2[1];
    end
    assign core_hash1 = pipe1;
    assign core_hash2 = pipe2[2];

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        logic [23:0] hash;
        int          ntries;
        int          done_rel;
    } exp_t;

    typedef struct {
        logic        real_m;
        logic [31:0] hit;
        logic [95:0] pay;
        logic [31:0] ns;
        logic [7:0]  tgt;
        exp_t        exp;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[8];

    function automatic exp_t ref_search(input logic [95:0] pay, input logic [31:0] ns,
                                        input logic [7:0] tgt);
        exp_t        e;
        logic [31:0] n;
        logic [23:0] h;
        n = ns;
        e = '{1'b0, 32'd0, 24'd0, 0, 0};
        for (int k = 1; k <= 1000; k++) begin
            h = mix_hash(mk_block(pay, n));
            e.nonce = n; e.hash = h; e.ntries = k; e.done_rel = 3 * k + 1;
            if (ref_qualify(h, tgt)) begin
                e.found = 1'b1;
                break;
            end
            if (n == 32'hFFFF_FFFF) break;
            n = n + 32'd1;
        end
        return e;
    endfunction

    function automatic vec_t mkv(input logic rm, input logic [31:0] hit, input logic [95:0] pay,
                                 input logic [31:0] ns, input logic [7:0] tgt, input logic f,
                                 input logic [31:0] en, input logic [23:0] eh, input int et,
                                 input int ed);
        vec_t v;
        v.real_m = rm; v.hit = hit; v.pay = pay; v.ns = ns; v.tgt = tgt;
        if (rm) v.exp = ref_search(pay, ns, tgt);
        else    v.exp = '{f, en, eh, et, ed};
        return v;
    endfunction

    task automatic setup(input vec_t v);
        real_mode = v.real_m; hit_nonce = v.hit; payload = v.pay;
        nonce_start = v.ns; target = v.tgt;
    endtask

    // Runs one search on dut1; optional start re-pulse at rel cycle 'glitch'
    // and optional abort asserted together with start.
    task automatic run_vec(input int idx, input int glitch, input bit abort_with_start);
        vec_t  v;
        exp_t  e;
        int    sc;
        int    rel;
        bit    got;
        v = vecs[idx];
        @(negedge clk);
        setup(v);
        start1 = 1'b1; abort = abort_with_start; sc = cyc;
        sb_q.push_back(v.exp);
        @(negedge clk);
        start1 = 1'b0; abort = 1'b0;
        chk($sformatf("v%0d_busy_c1", idx), busy1, 1'b1);
        chk($sformatf("v%0d_core_en_c1", idx), core_en1, 1'b1);
        chk($sformatf("v%0d_block_c1", idx), core_block1, mk_block(v.pay, v.ns));
        chk($sformatf("v%0d_found_clr", idx), {found1, nonce_out1, hash_out1}, 57'd0);
        got = 1'b0;
        rel = 1;
        while (!got && rel < 3200) begin
            rel = cyc - sc;
            start1 = (rel == glitch);
            if (done1 === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        start1 = 1'b0;
        chk($sformatf("v%0d_done_seen", idx), got, 1'b1);
        e = sb_q.pop_front();
        chk($sformatf("v%0d_done_cycle", idx), rel, e.done_rel);
        chk($sformatf("v%0d_found", idx), found1, e.found);
        chk($sformatf("v%0d_nonce_out", idx), nonce_out1, e.nonce);
        chk($sformatf("v%0d_hash_out", idx), hash_out1, e.hash);
        chk($sformatf("v%0d_tries", idx), tries1, tries_exp(e.ntries));
        @(negedge clk);
        chk($sformatf("v%0d_idle_after", idx), {busy1, done1}, 2'b00);
        chk($sformatf("v%0d_found_hold", idx), {found1, nonce_out1}, {e.found, e.nonce});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_status1"}, {busy1, done1, found1, core_en1}, 4'd0);
        chk({tag, "_data1"}, {nonce_out1, hash_out1, tries1}, 88'd0);
        chk({tag, "_block1"}, core_block1, 128'd0);
        chk({tag, "_status2"}, {busy2, done2, found2, core_en2}, 4'd0);
        chk({tag, "_data2"}, {nonce_out2, hash_out2, tries2, core_block2}, 216'd0);
    endtask

    typedef struct { logic [23:0] h; logic [7:0] t; } cmpv_t;

    initial begin
        cmpv_t cv[6];
        int    sc;
        int    dcnt;

        reset = 1'b1; abort = 1'b0; start1 = 1'b0; start2 = 1'b0;
        payload = 96'd0; nonce_start = 32'd0; target = 8'd0;
        real_mode = 1'b0; hit_nonce = 32'd0;
        cmp_hash = 24'd0; cmp_tgt = 8'd0;

        vecs[0] = mkv(1'b0, 32'd5, 96'hA5A5_0102_0304_0506_0708_090A, 32'd0, 8'h20,
                      1'b1, 32'd5, 24'h101000, 6, 19);
        vecs[1] = mkv(1'b0, 32'd5, 96'd0, 32'hFFFF_FFFE, 8'h20,
                      1'b0, 32'hFFFF_FFFF, 24'hFFFFFF, 2, 7);
        vecs[2] = mkv(1'b0, 32'd100, 96'd0, 32'd100, 8'h20,
                      1'b1, 32'd100, 24'h101000, 1, 4);
        vecs[3] = mkv(1'b0, 32'hFFFF_FFFE, 96'd0, 32'hFFFF_FFFD, 8'h10,
                      1'b0, 32'hFFFF_FFFF, 24'hFFFFFF, 3, 10);
        vecs[4] = mkv(1'b0, 32'hFFFF_FFFE, 96'd0, 32'hFFFF_FFFD, 8'h11,
                      1'b1, 32'hFFFF_FFFE, 24'h101000, 2, 7);
        vecs[5] = mkv(1'b0, 32'hFFFF_FFFF, 96'd0, 32'hFFFF_FFFF, 8'h00,
                      1'b0, 32'hFFFF_FFFF, 24'h101000, 1, 4);
        vecs[6] = mkv(1'b1, 32'd0, 96'd0, 32'd0, 8'hFF, 1'b0, 32'd0, 24'd0, 0, 0);
        vecs[7] = mkv(1'b1, 32'd0, 96'h0123_4567_89AB_CDEF_FEDC_BA98, 32'h1234_5678, 8'hC0,
                      1'b0, 32'd0, 24'd0, 0, 0);

        cv[0] = '{24'h1F1FFF, 8'h20};
        cv[1] = '{24'h201000, 8'h20};
        cv[2] = '{24'h102000, 8'h20};
        cv[3] = '{24'h000000, 8'h00};
        cv[4] = '{24'hFEFE00, 8'hFF};
        cv[5] = '{24'hFFFE00, 8'hFF};

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;

        // Comparator against the bench's own qualify rule.
        for (int i = 0; i < 6; i++) begin
            cmp_hash = cv[i].h; cmp_tgt = cv[i].t;
            #1;
            chk($sformatf("cmp_%0d", i), cmp_q, ref_qualify(cv[i].h, cv[i].t));
        end

        // Table-driven searches.
        for (int i = 0; i < 8; i++) run_vec(i, -1, 1'b0);

        // Abort in the ISSUE cycle of try 4.
        @(negedge clk);
        setup(vecs[0]);
        start1 = 1'b1; sc = cyc;
        @(negedge clk);
        start1 = 1'b0;
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_rel", cyc - sc, 11);
        chk("abort_status", {busy1, done1, found1}, 3'b000);
        chk("abort_nonce_out", nonce_out1, 32'd2);
        chk("abort_hash_out", hash_out1, 24'hFFFFFF);
        chk("abort_tries", tries1, tries_exp(4));
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dcnt += int'(done1);
        end
        chk("abort_no_done", dcnt, 0);

        // start re-pulsed while busy is ignored.
        run_vec(0, 4, 1'b0);

        // Abort in the CHECK cycle of a qualifying try beats the hit.
        @(negedge clk);
        setup(vecs[2]);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_chk_status", {busy1, done1, found1}, 3'b000);
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dcnt += int'(done1);
        end
        chk("abort_chk_no_done", dcnt, 0);

        // start and abort together in IDLE: start wins.
        run_vec(2, -1, 1'b1);

        // Reset in the middle of a search.
        @(negedge clk);
        setup(vecs[0]);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // CORE_LAT=3 instance, hit on the first nonce.
        real_mode = 1'b0; hit_nonce = 32'h40; nonce_start = 32'h40;
        target = 8'h20; payload = 96'd0;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int r = 1; r <= 8; r++) begin
            chk($sformatf("lat3_core_en_c%0d", r), core_en2, (r == 1));
            chk($sformatf("lat3_done_c%0d", r), done2, (r == 6));
            chk($sformatf("lat3_busy_c%0d", r), busy2, (r <= 6));
            @(negedge clk);
        end
        chk("lat3_found", found2, 1'b1);
        chk("lat3_nonce_out", nonce_out2, 32'h40);
        chk("lat3_hash_out", hash_out2, 24'h101000);
        chk("lat3_tries", tries2, tries_exp(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
